// File: rtl/char_rot_pkg.sv
// Shared character codes, FSM state constants and the power-on message for char_rotate_ctrl.
package char_rot_pkg;

    typedef logic [1:0] char_t;

    localparam char_t CH_D     = 2'b00;
    localparam char_t CH_E     = 2'b01;
    localparam char_t CH_ONE   = 2'b10;
    localparam char_t CH_BLANK = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LOAD = 2'b10;

    // Power-on message "dE1" followed by blanks, index 0 first.
    function automatic char_t default_char(input int unsigned idx);
        char_t c;
        case (idx)
            32'd0:   c = CH_D;
            32'd1:   c = CH_E;
            32'd2:   c = CH_ONE;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/char_rotate_ctrl_rate_divider.sv
// Rotation-rate divider: counts enabled cycles and flags the terminal count of each TICK_DIV period.
module rate_divider #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_r;

    // Terminal flag is combinational so the owner can act on it in the same edge; clr does not mask it.
    assign tick = en && (div_cnt_r == CNT_LAST);

    // Period counter: clear wins, otherwise wrap at the terminal count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_r <= CNT_W'(0);
        end else if (clr) begin
            div_cnt_r <= CNT_W'(0);
        end else if (en) begin
            if (div_cnt_r == CNT_LAST) begin
                div_cnt_r <= CNT_W'(0);
            end else begin
                div_cnt_r <= div_cnt_r + CNT_W'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule

// File: rtl/char_rotate_ctrl.sv
// Message ring + rotating display window scheduler for the HEX character decoders.
// Optional feature: define ROT_MANUAL_STEP_EN to add a manual single-step input while idle.
module char_rotate_ctrl
    import char_rot_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int NUM_DISP = 6,
    parameter int MSG_LEN  = 6
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  wr_valid,
    input  logic [1:0]            wr_data,
`ifdef ROT_MANUAL_STEP_EN
    input  logic                  step,
`endif
    output logic                  wr_ready,
    output logic [2*NUM_DISP-1:0] disp_codes,
    output logic                  tick,
    output logic                  busy
);

    localparam int               OFF_W     = $clog2(MSG_LEN);
    localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(MSG_LEN - 1);
    localparam logic [OFF_W:0]   MSG_LEN_W = (OFF_W + 1)'(MSG_LEN);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [OFF_W-1:0]      offset_r;
    logic [OFF_W-1:0]      wr_idx_r;
    char_t                 msg_r [MSG_LEN];
    logic [OFF_W-1:0]      off_inc_s;
    logic [OFF_W-1:0]      off_dec_s;
    logic                  div_tick_s;
    logic                  div_clr_s;
    logic                  div_en_s;
    logic                  wr_acc_s;
    logic                  wr_last_s;
    logic                  man_step_s;
    logic                  tick_r;
    logic                  busy_r;
    logic                  wr_ready_r;
    logic [2*NUM_DISP-1:0] disp_codes_s;

    // offset and i are both below MSG_LEN, so one conditional subtract wraps the sum.
    function automatic logic [OFF_W-1:0] ring_idx(input logic [OFF_W-1:0] base, input int unsigned i);
        logic [OFF_W:0] sum;
        sum = {1'b0, base} + (OFF_W + 1)'(i);
        if (sum >= MSG_LEN_W) begin
            sum = sum - MSG_LEN_W;
        end else begin
            sum = sum;
        end
        return sum[OFF_W-1:0];
    endfunction

    assign div_en_s  = (state_r == ST_RUN);
    assign div_clr_s = !((state_r == ST_RUN) && run);

    rate_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_rate_divider (
        .clk    (CLOCK_50),
        .resetn (resetn),
        .clr    (div_clr_s),
        .en     (div_en_s),
        .tick   (div_tick_s)
    );

    // Neighbouring offsets with wrap in both rotation directions.
    always_comb begin
        off_inc_s = (offset_r == LAST_OFF) ? OFF_W'(0) : offset_r + OFF_W'(1);
        off_dec_s = (offset_r == OFF_W'(0)) ? LAST_OFF : offset_r - OFF_W'(1);
    end

    // Next-state and write-accept decode; a write offered in IDLE beats run and step.
    always_comb begin
        state_nxt_s = state_r;
        wr_acc_s    = 1'b0;
        wr_last_s   = 1'b0;
        man_step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_valid) begin
                    wr_acc_s    = 1'b1;
                    state_nxt_s = ST_LOAD;
                end else begin
`ifdef ROT_MANUAL_STEP_EN
                    man_step_s = step;
`else
                    man_step_s = 1'b0;
`endif
                    if (run) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (run) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (wr_valid) begin
                    wr_acc_s = 1'b1;
                    if (wr_idx_r == LAST_OFF) begin
                        wr_last_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, window offset, write pointer and the registered status outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            offset_r   <= OFF_W'(0);
            wr_idx_r   <= OFF_W'(0);
            tick_r     <= 1'b0;
            busy_r     <= 1'b0;
            wr_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            tick_r     <= div_tick_s;
            busy_r     <= (state_nxt_s == ST_RUN);
            wr_ready_r <= (state_nxt_s != ST_RUN);
            if (wr_last_s) begin
                offset_r <= OFF_W'(0);
            end else if (div_tick_s || man_step_s) begin
                offset_r <= dir ? off_dec_s : off_inc_s;
            end else begin
                offset_r <= offset_r;
            end
            if (wr_last_s) begin
                wr_idx_r <= OFF_W'(0);
            end else if (wr_acc_s) begin
                wr_idx_r <= wr_idx_r + OFF_W'(1);
            end else begin
                wr_idx_r <= wr_idx_r;
            end
        end
    end

    // Message ring: reset restores the default text, accepted writes land at the write pointer.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_r[i] <= default_char(i);
            end
        end else if (wr_acc_s) begin
            msg_r[wr_idx_r] <= wr_data;
        end
    end

    // Display window follows the ring and offset without a register stage.
    always_comb begin
        disp_codes_s = '0;
        for (int i = 0; i < NUM_DISP; i++) begin
            disp_codes_s[2*i +: 2] = msg_r[ring_idx(offset_r, i)];
        end
    end

    assign disp_codes = disp_codes_s;
    assign tick       = tick_r;
    assign busy       = busy_r;
    assign wr_ready   = wr_ready_r;

endmodule

// File: tb/tb_char_rotate_ctrl.sv
// Self-checking bench for char_rotate_ctrl (TICK_DIV=4, NUM_DISP=4, MSG_LEN=6) with a behavioural model.
module tb_char_rotate_ctrl;

    localparam int TD = 4;
    localparam int ND = 4;
    localparam int ML = 6;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOAD = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          run = 1'b0;
    logic          dir = 1'b0;
    logic          wr_valid = 1'b0;
    logic [1:0]    wr_data = 2'b00;
    logic          step_tb = 1'b0;
    logic          wr_ready;
    logic          tick;
    logic          busy;
    logic [2*ND-1:0] disp_codes;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: message contents, window offset, mode, cycles spent running, chars loaded
    logic [1:0] m_msg [ML];
    int         m_off;
    int         m_mode;
    int         m_age;
    int         m_wcnt;
    logic       m_tick;

    char_rotate_ctrl #(.TICK_DIV(TD), .NUM_DISP(ND), .MSG_LEN(ML)) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .run        (run),
        .dir        (dir),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
`ifdef ROT_MANUAL_STEP_EN
        .step       (step_tb),
`endif
        .wr_ready   (wr_ready),
        .disp_codes (disp_codes),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*ND-1:0] exp_win();
        logic [2*ND-1:0] w;
        for (int i = 0; i < ND; i++) w[2*i +: 2] = m_msg[(m_off + i) % ML];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ML; i++) m_msg[i] = (i < 3) ? 2'(i) : 2'b11;
        m_off = 0; m_mode = M_IDLE; m_age = 0; m_wcnt = 0; m_tick = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0; run = 1'b0; dir = 1'b0; wr_valid = 1'b0; wr_data = 2'b00; step_tb = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Apply the rules to the inputs currently driven, then let one rising edge pass.
    task automatic cycle();
        m_tick = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (wr_valid) begin
                    m_msg[0] = wr_data; m_wcnt = 1; m_mode = M_LOAD;
                end else begin
                    if (step_tb) m_off = dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
                    if (run) begin m_mode = M_RUN; m_age = 0; end
                end
            end
            M_RUN: begin
                m_age++;
                if (m_age % TD == 0) begin
                    m_tick = 1'b1;
                    m_off = dir ? (m_off + ML - 1) % ML : (m_off + 1) % ML;
                end
                if (!run) m_mode = M_IDLE;
            end
            M_LOAD: begin
                if (wr_valid) begin
                    m_msg[m_wcnt] = wr_data; m_wcnt++;
                    if (m_wcnt == ML) begin m_wcnt = 0; m_off = 0; m_mode = M_IDLE; end
                end
            end
            default: ;
        endcase
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (disp_codes !== 8'b11_10_01_00) begin n_bad++; $display("FAIL reset_disp got %b want %b", disp_codes, 8'b11_10_01_00); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", tick); end
    endtask

    task automatic test_rotate_left();
        do_reset();
        run = 1'b1; dir = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            cycle();
            n_cmp++;
            if ({disp_codes, tick, busy, wr_ready} !== {exp_win(), m_tick, m_mode == M_RUN, m_mode != M_RUN}) begin
                n_bad++;
                $display("FAIL left_cyc%0d got disp=%b tick=%b busy=%b rdy=%b want disp=%b tick=%b busy=%b rdy=%b",
                         k, disp_codes, tick, busy, wr_ready, exp_win(), m_tick, m_mode == M_RUN, m_mode != M_RUN);
            end
            if (k == 5) begin
                n_cmp++; if ({tick, disp_codes[1:0]} !== 3'b1_01) begin n_bad++; $display("FAIL left_first_tick got tick=%b disp0=%b want tick=1 disp0=01", tick, disp_codes[1:0]); end
            end
        end
        n_cmp++; if (disp_codes !== 8'b11_10_01_00) begin n_bad++; $display("FAIL left_six_ticks got %b want %b", disp_codes, 8'b11_10_01_00); end
        run = 1'b0;
        cycle();
    endtask

    task automatic test_rotate_right();
        do_reset();
        run = 1'b1; dir = 1'b1;
        for (int k = 1; k <= 5; k++) cycle();
        n_cmp++; if ({tick, disp_codes[3:0]} !== 5'b1_00_11) begin n_bad++; $display("FAIL right_first_tick got tick=%b disp1,0=%b want tick=1 disp1,0=0011", tick, disp_codes[3:0]); end
        for (int k = 0; k < 40; k++) begin
            dir = 1'($urandom_range(0, 1));
            cycle();
            n_cmp++;
            if ({disp_codes, tick, busy} !== {exp_win(), m_tick, m_mode == M_RUN}) begin
                n_bad++;
                $display("FAIL randdir_cyc%0d got disp=%b tick=%b busy=%b want disp=%b tick=%b busy=%b",
                         k, disp_codes, tick, busy, exp_win(), m_tick, m_mode == M_RUN);
            end
        end
        run = 1'b0;
        cycle();
    endtask

    task automatic test_load();
        logic [1:0] seq [ML];
        int accepted;
        int guard;
        seq[0] = 2'b10; seq[1] = 2'b10; seq[2] = 2'b00; seq[3] = 2'b00; seq[4] = 2'b01; seq[5] = 2'b01;
        do_reset();
        for (int j = 0; j < ML; j++) begin
            wr_valid = 1'b1; wr_data = seq[j]; run = (j > 0);
            cycle();
            n_cmp++;
            if ({wr_ready, tick, busy} !== 3'b100) begin
                n_bad++;
                $display("FAIL load_fixed_w%0d got rdy=%b tick=%b busy=%b want rdy=1 tick=0 busy=0", j, wr_ready, tick, busy);
            end
        end
        wr_valid = 1'b0; run = 1'b0;
        n_cmp++; if (disp_codes !== 8'b00_00_10_10) begin n_bad++; $display("FAIL load_fixed_win got %b want %b", disp_codes, 8'b00_00_10_10); end
        cycle();
        n_cmp++; if ({busy, wr_ready} !== 2'b01) begin n_bad++; $display("FAIL load_fixed_idle got busy=%b rdy=%b want busy=0 rdy=1", busy, wr_ready); end
        // randomly gapped writes with run toggling while loading
        accepted = 0; guard = 0;
        while (accepted < ML && guard < 80) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 2'($urandom_range(0, 3));
            run      = (m_mode == M_LOAD) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (wr_valid) accepted++;
            cycle();
            guard++;
            n_cmp++;
            if ({disp_codes, tick, busy, wr_ready} !== {exp_win(), m_tick, m_mode == M_RUN, m_mode != M_RUN}) begin
                n_bad++;
                $display("FAIL load_rand_cyc%0d got disp=%b tick=%b busy=%b rdy=%b want disp=%b tick=%b busy=%b rdy=%b",
                         guard, disp_codes, tick, busy, wr_ready, exp_win(), m_tick, m_mode == M_RUN, m_mode != M_RUN);
            end
        end
        wr_valid = 1'b0; run = 1'b0;
        n_cmp++; if (accepted !== ML) begin n_bad++; $display("FAIL load_rand_budget got %0d accepts want %0d", accepted, ML); end
    endtask

    task automatic test_pause();
        int waited;
        do_reset();
        run = 1'b1; dir = 1'b0;
        for (int k = 1; k <= 3; k++) cycle();
        run = 1'b0;
        cycle();
        n_cmp++; if ({tick, busy, disp_codes} !== {1'b0, 1'b0, exp_win()}) begin n_bad++; $display("FAIL pause_stop got tick=%b busy=%b disp=%b want tick=0 busy=0 disp=%b", tick, busy, disp_codes, exp_win()); end
        run = 1'b1;
        cycle();
        waited = 0;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            n_cmp++;
            if ({disp_codes, tick, busy} !== {exp_win(), m_tick, m_mode == M_RUN}) begin
                n_bad++;
                $display("FAIL pause_resume_cyc%0d got disp=%b tick=%b busy=%b want disp=%b tick=%b busy=%b",
                         c, disp_codes, tick, busy, exp_win(), m_tick, m_mode == M_RUN);
            end
            if (tick === 1'b1) begin waited = c; break; end
        end
        n_cmp++; if (waited !== TD) begin n_bad++; $display("FAIL pause_tick_delay got %0d cycles want %0d", waited, TD); end
        for (int c = 0; c < 3; c++) cycle();
        run = 1'b0;
        cycle();
        n_cmp++; if ({tick, busy, disp_codes[1:0]} !== 4'b1_0_10) begin n_bad++; $display("FAIL stop_on_tick got tick=%b busy=%b disp0=%b want tick=1 busy=0 disp0=10", tick, busy, disp_codes[1:0]); end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        for (int j = 0; j < 3; j++) begin
            wr_valid = 1'b1; wr_data = 2'($urandom_range(0, 3));
            cycle();
        end
        wr_valid = 1'b0;
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if ({disp_codes, wr_ready, busy} !== {8'b11_10_01_00, 1'b1, 1'b0}) begin n_bad++; $display("FAIL midload_reset got disp=%b rdy=%b busy=%b want disp=11100100 rdy=1 busy=0", disp_codes, wr_ready, busy); end
        @(negedge clk);
        resetn = 1'b1;
        for (int j = 0; j < ML; j++) begin
            wr_valid = 1'b1; wr_data = 2'($urandom_range(0, 3));
            cycle();
        end
        wr_valid = 1'b0;
        n_cmp++; if ({disp_codes, busy, wr_ready} !== {exp_win(), 1'b0, 1'b1}) begin n_bad++; $display("FAIL midload_reload got disp=%b busy=%b rdy=%b want disp=%b busy=0 rdy=1", disp_codes, busy, wr_ready, exp_win()); end
    endtask

`ifdef ROT_MANUAL_STEP_EN
    task automatic test_manual_step();
        do_reset();
        step_tb = 1'b1; dir = 1'b0;
        cycle();
        step_tb = 1'b0;
        n_cmp++; if ({tick, disp_codes[1:0]} !== 3'b0_01) begin n_bad++; $display("FAIL step_idle got tick=%b disp0=%b want tick=0 disp0=01", tick, disp_codes[1:0]); end
        run = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step_tb = 1'($urandom_range(0, 1));
            cycle();
            n_cmp++;
            if ({disp_codes, tick} !== {exp_win(), m_tick}) begin
                n_bad++;
                $display("FAIL step_run_cyc%0d got disp=%b tick=%b want disp=%b tick=%b", k, disp_codes, tick, exp_win(), m_tick);
            end
        end
        step_tb = 1'b0; run = 1'b0;
        cycle();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            dir      = 1'($urandom_range(0, 1));
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_data  = 2'($urandom_range(0, 3));
            cycle();
            n_cmp++;
            if ({disp_codes, tick, busy, wr_ready} !== {exp_win(), m_tick, m_mode == M_RUN, m_mode != M_RUN}) begin
                n_bad++;
                $display("FAIL random_cyc%0d got disp=%b tick=%b busy=%b rdy=%b want disp=%b tick=%b busy=%b rdy=%b",
                         k, disp_codes, tick, busy, wr_ready, exp_win(), m_tick, m_mode == M_RUN, m_mode != M_RUN);
            end
        end
        run = 1'b0; wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_load();
        test_pause();
        test_reset_mid_load();
`ifdef ROT_MANUAL_STEP_EN
        test_manual_step();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
